shift_receiver: RTL and testbench

SHIFT_RECEIVER -- requirements
Module: shift_receiver

---
 rtl/shift_receiver_pkg.sv | 12 +
 rtl/shift_receiver.sv | 103 ++++++++++
 tb/tb_shift_receiver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_receiver_pkg.sv
// Shared definitions for the serial receive path and its downstream transmitter.
package shift_receiver_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W         = 6;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/shift_receiver.sv
// MSB-first serial-to-parallel receiver with a one-word output holding register.
// Handshake: a word moves downstream on a rising edge where out_valid=1 and out_ready=1.
module shift_receiver
    import shift_receiver_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    input  logic             abort,
    input  logic             clear_overflow,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] bit_count,
    output logic             overflow,
    output logic             busy
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic             complete;
    logic [WIDTH-1:0] word_w;

    assign word_w = {shift_q[WIDTH-2:0], in};

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        if (abort) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (enable) begin
            shift_d = word_w;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    // A clear and a new drop on the same edge leave the flag set.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (clear_overflow) ovf_d = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    data_d  = word_w;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (complete) begin
                    if (out_ready) data_d = word_w;
                    else           ovf_d  = 1'b1;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The FSM state is directly visible as out_valid.
    assign out_data  = data_q;
    assign out_valid = (state_q == ST_FULL);
    assign bit_count = cnt_q;
    assign overflow  = ovf_q;
    assign busy      = (cnt_q != '0);

    a_valid_known: assert property (@(posedge clk) disable iff (!reset) !$isunknown(out_valid));
    a_count_range: assert property (@(posedge clk) disable iff (!reset) 32'(bit_count) < WIDTH);
    a_data_hold:   assert property (@(posedge clk) disable iff (!reset)
                                    (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_shift_receiver.sv
// Bench for shift_receiver: directed scenarios plus random traffic against a bit-queue model.
module tb_shift_receiver;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable, in_bit, abort, clear_overflow, out_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [5:0]    bit_count;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    shift_receiver #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in             (in_bit),
        .abort          (abort),
        .clear_overflow (clear_overflow),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .bit_count      (bit_count),
        .overflow       (overflow),
        .busy           (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Partial word is kept as a queue of received bits; its size is the bit count.
    bit          m_bits[$];
    logic [W-1:0] m_data  = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf   = 1'b0;

    task automatic model_reset();
        m_bits.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clk) begin
        logic         done;
        logic [W-1:0] w;
        if (!reset) begin
            model_reset();
        end else begin
            done = 1'b0;
            w    = '0;
            if (abort) begin
                m_bits.delete();
            end else if (enable) begin
                m_bits.push_back(in_bit);
                if (m_bits.size() == W) begin
                    foreach (m_bits[k]) w = {w[W-2:0], m_bits[k]};
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            if (clear_overflow) m_ovf = 1'b0;
            if (done) begin
                if (!m_valid)      begin m_data = w; m_valid = 1'b1; end
                else if (out_ready) m_data = w;
                else                m_ovf  = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #2;
        check("cyc_out_data",  64'(out_data),  64'(m_data));
        check("cyc_out_valid", 64'(out_valid), 64'(m_valid));
        check("cyc_bit_count", 64'(bit_count), 64'(m_bits.size()));
        check("cyc_overflow",  64'(overflow),  64'(m_ovf));
        check("cyc_busy",      64'(busy),      64'(m_bits.size() != 0));
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic e, input logic b, input logic a, input logic c, input logic r);
        @(negedge clk);
        enable         = e;
        in_bit         = b;
        abort          = a;
        clear_overflow = c;
        out_ready      = r;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic shift_word(input logic [W-1:0] w, input logic r);
        for (int i = W - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0, 1'b0, r);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w;
        reset = 1'b0;
        enable = 1'b0; in_bit = 1'b0; abort = 1'b0; clear_overflow = 1'b0; out_ready = 1'b0;
        idle(1'b1);
        idle(1'b1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_bit_count", 64'(bit_count), 64'd0);
        @(negedge clk) reset = 1'b1;

        // Continuous shift, downstream always ready
        w = 32'hDEADBEEF;
        for (int i = W - 1; i >= 1; i--) drive(1'b1, w[i], 1'b0, 1'b0, 1'b1);
        drive(1'b1, w[0], 1'b0, 1'b0, 1'b1);
        check("dead_valid_before", 64'(out_valid), 64'd0);
        check("dead_count_31",     64'(bit_count), 64'd31);
        idle(1'b1);
        check("dead_valid", 64'(out_valid), 64'd1);
        check("dead_data",  64'(out_data),  64'hDEADBEEF);
        check("dead_count", 64'(bit_count), 64'd0);
        idle(1'b1);
        check("dead_drained", 64'(out_valid), 64'd0);

        // Second word dropped while the first is held
        shift_word(32'h11111111, 1'b0);
        shift_word(32'h22222222, 1'b0);
        idle(1'b0);
        check("ovf_data",  64'(out_data),  64'h11111111);
        check("ovf_valid", 64'(out_valid), 64'd1);
        check("ovf_set",   64'(overflow),  64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Ready on the completing edge replaces the held word
        idle(1'b1);
        idle(1'b0);
        check("xfer_empty", 64'(out_valid), 64'd0);
        shift_word(32'hAAAAAAAA, 1'b0);
        idle(1'b0);
        check("xfer_held", 64'(out_data), 64'hAAAAAAAA);
        w = 32'h55555555;
        for (int i = W - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0, 1'b0, i == 0);
        idle(1'b0);
        check("xfer_data",  64'(out_data),  64'h55555555);
        check("xfer_valid", 64'(out_valid), 64'd1);
        check("xfer_ovf",   64'(overflow),  64'd0);
        idle(1'b1);

        // Abort mid-word, with enable high on the abort edge
        for (int i = 0; i < 10; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("abort_pre_count", 64'(bit_count), 64'd10);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        check("abort_count", 64'(bit_count), 64'd0);
        check("abort_busy",  64'(busy),      64'd0);
        shift_word(32'h12345678, 1'b0);
        idle(1'b0);
        check("abort_data", 64'(out_data), 64'h12345678);
        idle(1'b1);

        // Enable gaps between bits
        w = 32'hA5A5A5A5;
        for (int i = W - 1; i >= 0; i--) begin
            drive(1'b1, w[i], 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        idle(1'b0);
        check("gap_data", 64'(out_data), 64'hA5A5A5A5);

        // Reset in the middle of a word
        for (int i = 0; i < 16; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;
        #1;
        check("mid_rst_data",  64'(out_data),  64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(bit_count), 64'd0);
        check("mid_rst_ovf",   64'(overflow),  64'd0);
        check("mid_rst_busy",  64'(busy),      64'd0);
        idle(1'b0);
        @(negedge clk) reset = 1'b1;
        w = $urandom;
        shift_word(w, 1'b0);
        idle(1'b0);
        check("post_rst_data",  64'(out_data),  64'(w));
        check("post_rst_valid", 64'(out_valid), 64'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)));
        end
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
